gcd_arbiter: RTL and testbench

Shared GCD engine scheduler: accepts operand pairs from `NREQ` requesters, grants them round-robin to a single subtractive GCD datapath, sequences the iterate/compare loop, and returns a tagged result through a valid/ready response port. It sits between the client blocks and the GCD datapath, so one subtract/compare unit serves all clients.

---
 rtl/gcd_pkg.sv | 20 ++
 rtl/gcd_arbiter_if.sv | 38 +++
 rtl/gcd_rr_arbiter.sv | 43 ++++
 rtl/gcd_arbiter.sv | 168 ++++++++++++++++
 tb/tb_gcd_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types and constants for the GCD arbiter slice.
//   gcd_arb_state_t : scheduler FSM states (IDLE / CALC / DONE)
//   DEFAULT_WIDTH   : default operand/result width
//   id_width()      : width of a requester index for a given requester count
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_arb_state_t;

  localparam int DEFAULT_WIDTH = 16;

  // A single requester still needs a 1-bit id field.
  function automatic int id_width(input int nreq);
    return (nreq <= 1) ? 1 : $clog2(nreq);
  endfunction

endpackage

// File: rtl/gcd_arbiter_if.sv
// gcd_arbiter_if: request/response bundle between the clients and the GCD
// scheduler.
//   req_valid/req_ready : per-requester handshake (req_ready is one-hot)
//   req_a/req_b         : packed operands, slice i belongs to requester i
//   rsp_valid/rsp_ready : result handshake
//   rsp_id/rsp_gcd/rsp_err : tagged result and timeout flag
//   busy                : scheduler is not idle
// modport master = client side, modport slave = scheduler side.
interface gcd_arbiter_if
  import gcd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NREQ  = 4
);
  localparam int IDW = id_width(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_gcd;
  logic                  rsp_err;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_gcd, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_gcd, rsp_err, busy
  );

endinterface

// File: rtl/gcd_rr_arbiter.sv
// gcd_rr_arbiter: combinational round-robin picker.
//   req_valid : per-requester valid
//   ptr       : highest-priority requester index this cycle
//   grant     : one-hot grant of the first valid requester at or after ptr
//   grant_id  : index of that requester (0 when nothing is valid)
module gcd_rr_arbiter
  import gcd_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  logic [IDW:0]   idx_wide;
  logic [IDW-1:0] idx;
  logic           found;

  // Walk offsets 0..NREQ-1 from ptr; one extra bit lets the sum wrap cleanly.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx_wide = '0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_wide = {1'b0, ptr} + (IDW+1)'(k);
      if (idx_wide >= (IDW+1)'(NREQ)) begin
        idx_wide = idx_wide - (IDW+1)'(NREQ);
      end
      idx = idx_wide[IDW-1:0];
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: shared subtractive GCD engine with round-robin admission.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : gcd_arbiter_if.slave (requests in, tagged result out)
// One job at a time: IDLE grants a requester, CALC does one compare/subtract
// step per cycle, DONE presents the result until rsp_ready.
// Optional feature macro: GCD_ARB_TIMEOUT_EN -- CALC is cut off after
// MAX_ITER cycles and reported with rsp_err=1, rsp_gcd=0.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int NREQ     = 4,
  parameter int MAX_ITER = 1024
) (
  input  logic             clk,
  input  logic             rst,
  gcd_arbiter_if.slave     bus
);

  localparam int IDW = id_width(NREQ);

  if (NREQ < 2) begin : g_bad_nreq
    $error("gcd_arbiter: NREQ must be at least 2");
  end
  if (MAX_ITER < 1) begin : g_bad_max_iter
    $error("gcd_arbiter: MAX_ITER must be at least 1");
  end

  gcd_arb_state_t   state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
`ifdef GCD_ARB_TIMEOUT_EN
  localparam int ITW = $clog2(MAX_ITER + 1);
  logic             err_q, err_d;
  logic [ITW-1:0]   iter_q, iter_d;
`endif

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_id;
  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];

  // Unpack the flat operand buses so the granted pair can be selected by id.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign op_a[gi] = bus.req_a[gi*WIDTH +: WIDTH];
    assign op_b[gi] = bus.req_b[gi*WIDTH +: WIDTH];
  end

  gcd_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req_valid (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      gcd_q   <= '0;
`ifdef GCD_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
      iter_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      gcd_q   <= gcd_d;
`ifdef GCD_ARB_TIMEOUT_EN
      err_q   <= err_d;
      iter_q  <= iter_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    id_d          = id_q;
    ptr_d         = ptr_q;
    gcd_d         = gcd_q;
`ifdef GCD_ARB_TIMEOUT_EN
    err_d         = err_q;
    iter_d        = iter_q;
`endif
    bus.req_ready = '0;
    case (state_q)
      IDLE: begin
        // The grant is a subset of req_valid, so any valid means a transfer.
        if (|bus.req_valid) begin
          bus.req_ready = grant;
          a_d           = op_a[grant_id];
          b_d           = op_b[grant_id];
          id_d          = grant_id;
          ptr_d         = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
          state_d       = CALC;
`ifdef GCD_ARB_TIMEOUT_EN
          iter_d        = '0;
`endif
        end
      end
      CALC: begin
        // Termination checks outrank subtraction; A==B also covers gcd(0,0).
        if (a_q == b_q) begin
          gcd_d   = a_q;
          state_d = DONE;
`ifdef GCD_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end else if (a_q == '0) begin
          gcd_d   = b_q;
          state_d = DONE;
`ifdef GCD_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end else if (b_q == '0) begin
          gcd_d   = a_q;
          state_d = DONE;
`ifdef GCD_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        // iter_q counts completed CALC cycles, so this is cycle MAX_ITER.
        end else if (iter_q == ITW'(MAX_ITER - 1)) begin
          gcd_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
`endif
        end else if (a_q > b_q) begin
          a_d = a_q - b_q;
        end else begin
          b_d = b_q - a_q;
        end
`ifdef GCD_ARB_TIMEOUT_EN
        iter_d = iter_q + 1'b1;
`endif
      end
      DONE: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_gcd   = gcd_q;
  assign bus.busy      = (state_q != IDLE);
`ifdef GCD_ARB_TIMEOUT_EN
  assign bus.rsp_err   = err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: self-checking bench for gcd_arbiter.
// A transaction-level model (Euclid with division, round-robin pick from a
// pointer, latency from the quotient sum) predicts every output each cycle.
// Build with +define+GCD_ARB_TIMEOUT_EN to exercise the timeout variant.
module tb_gcd_arbiter;
  import gcd_pkg::*;

  localparam int W    = 16;
  localparam int N    = 4;
  localparam int MAXI = 1024;

  localparam int P_WAIT    = 0;
  localparam int P_CALC    = 1;
  localparam int P_PRESENT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcd_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

  gcd_arbiter #(.WIDTH(W), .NREQ(N), .MAX_ITER(MAXI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Subtractive GCD performs sum(quotients)-1 subtractions plus one final
  // CALC cycle, so the CALC cycle count equals the Euclid quotient sum.
  function automatic void ref_job(input int unsigned a, input int unsigned b,
                                  output int unsigned g, output int unsigned k,
                                  output bit e);
    int unsigned x, y, t, qs;
    e = 1'b0;
    if (a == 0 || b == 0) begin
      g = a | b;
      k = 1;
    end else begin
      x = a; y = b; qs = 0;
      while (y != 0) begin
        qs += x / y;
        t = x % y;
        x = y;
        y = t;
      end
      g = x;
      k = qs;
    end
`ifdef GCD_ARB_TIMEOUT_EN
    if (k > MAXI) begin
      k = MAXI;
      g = 0;
      e = 1'b1;
    end
`endif
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  int          m_phase = P_WAIT;
  int          m_ptr   = 0;
  int          m_left  = 0;
  int          m_id    = 0;
  int unsigned m_g     = 0;
  int unsigned m_k     = 0;
  bit          m_e     = 1'b0;
  int          pick;
  logic [N-1:0] exp_rdy;
  logic [N-1:0] xfer_seen = '0;

  int cyc = 0, acc_cyc = 0, lat_now = 0;
  bit prev_rv = 1'b0;

  int unsigned log_id[$], log_gcd[$], log_err[$], log_lat[$];

  // Single compare process: all outputs against the model on every cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_phase   = P_WAIT;
      m_ptr     = 0;
      xfer_seen = '0;
      prev_rv   = 1'b0;
    end else begin
      pick    = (m_phase == P_WAIT) ? rr_pick(bus.req_valid, m_ptr) : -1;
      exp_rdy = '0;
      if (pick >= 0) exp_rdy[pick] = 1'b1;
      check("req_ready", bus.req_ready, exp_rdy);
      check("busy", bus.busy, m_phase != P_WAIT);
      check("rsp_valid", bus.rsp_valid, m_phase == P_PRESENT);
      if (m_phase == P_PRESENT) begin
        check("rsp_id", bus.rsp_id, m_id);
        check("rsp_gcd", bus.rsp_gcd, m_g);
        check("rsp_err", bus.rsp_err, m_e);
      end
      xfer_seen = bus.req_valid & bus.req_ready;
      if (xfer_seen != '0) acc_cyc = cyc;
      if (bus.rsp_valid && !prev_rv) lat_now = cyc - acc_cyc;
      prev_rv = bus.rsp_valid;

      if (m_phase == P_PRESENT) begin
        if (bus.rsp_ready) begin
          log_id.push_back(bus.rsp_id);
          log_gcd.push_back(bus.rsp_gcd);
          log_err.push_back(bus.rsp_err);
          log_lat.push_back(lat_now);
          $display("rsp id=%0d gcd=%0d err=%0d calc_cycles=%0d", bus.rsp_id, bus.rsp_gcd,
                   bus.rsp_err, lat_now - 1);
          m_phase = P_WAIT;
        end
      end else if (m_phase == P_CALC) begin
        m_left--;
        if (m_left == 0) m_phase = P_PRESENT;
      end else if (pick >= 0) begin
        ref_job(bus.req_a[pick*W +: W], bus.req_b[pick*W +: W], m_g, m_k, m_e);
        m_id    = pick;
        m_ptr   = (pick + 1) % N;
        m_left  = m_k;
        m_phase = P_CALC;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [N-1:0] pend_v = '0;
  logic [W-1:0] pend_a [N];
  logic [W-1:0] pend_b [N];

  task automatic drive();
    bus.req_valid = pend_v;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = pend_a[i];
      bus.req_b[i*W +: W] = pend_b[i];
    end
  endtask

  // Advance one clock; requesters whose transfer was seen drop their request.
  task automatic step();
    @(posedge clk);
    #1;
    pend_v = pend_v & ~xfer_seen;
    drive();
  endtask

  task automatic post(input int i, input int unsigned a, input int unsigned b);
    pend_v[i] = 1'b1;
    pend_a[i] = W'(a);
    pend_b[i] = W'(b);
    drive();
  endtask

  task automatic wait_log(input int n, input int budget);
    int c = 0;
    while (log_id.size() < n && c < budget) begin
      step();
      c++;
    end
    check("wait_response", log_id.size() >= n, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pend_v = '0;
    drive();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_id"}, bus.rsp_id, 0);
    check({tag, "_rsp_gcd"}, bus.rsp_gcd, 0);
    check({tag, "_rsp_err"}, bus.rsp_err, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  function automatic int unsigned rnd_op();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 0;
    return $urandom_range(1, 255);
  endfunction

  int unsigned g0, k0;
  bit e0;
  int base, cnt;

  initial begin
    for (int i = 0; i < N; i++) begin
      pend_a[i] = '0;
      pend_b[i] = '0;
    end
    bus.rsp_ready = 1'b0;
    drive();

    // Model pins against hand-computed values.
    ref_job(12, 8, g0, k0, e0);
    check("model_12_8_gcd", g0, 4);
    check("model_12_8_calc", k0, 3);
    ref_job(0, 0, g0, k0, e0);
    check("model_0_0_gcd", g0, 0);
    check("model_0_0_calc", k0, 1);
    ref_job(35, 21, g0, k0, e0);
    check("model_35_21_gcd", g0, 7);

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    step();
    rst = 1'b0;

    // (12,8) from requester 2.
    bus.rsp_ready = 1'b1;
    post(2, 12, 8);
    wait_log(1, 50);
    check("t1_id", log_id[0], 2);
    check("t1_gcd", log_gcd[0], 4);
    check("t1_err", log_err[0], 0);
    check("t1_calc", log_lat[0] - 1, 3);

    // Three simultaneous requesters after a fresh reset.
    do_reset();
    post(0, 9, 6);
    post(1, 7, 7);
    post(3, 0, 5);
    wait_log(4, 100);
    check("t2_id0", log_id[1], 0);
    check("t2_id1", log_id[2], 1);
    check("t2_id2", log_id[3], 3);
    check("t2_gcd0", log_gcd[1], 3);
    check("t2_gcd1", log_gcd[2], 7);
    check("t2_gcd2", log_gcd[3], 5);
    check("t2_calc_equal", log_lat[2] - 1, 1);
    check("t2_model_ptr", m_ptr, 0);

    // gcd(0,0) then (35,21).
    step();
    post(1, 0, 0);
    wait_log(5, 50);
    check("t3_gcd00", log_gcd[4], 0);
    check("t3_calc00", log_lat[4] - 1, 1);
    post(1, 35, 21);
    wait_log(6, 50);
    check("t3_gcd", log_gcd[5], 7);

    // Back-pressure in DONE with another request pending.
    bus.rsp_ready = 1'b0;
    post(0, 12, 18);
    cnt = 0;
    while (!bus.rsp_valid && cnt < 50) begin
      step();
      cnt++;
    end
    check("t4_rsp_seen", bus.rsp_valid, 1);
    post(3, 5, 10);
    repeat (5) step();
    check("t4_hold_valid", bus.rsp_valid, 1);
    check("t4_hold_gcd", bus.rsp_gcd, 6);
    check("t4_hold_id", bus.rsp_id, 0);
    check("t4_hold_ready", bus.req_ready, 0);
    bus.rsp_ready = 1'b1;
    wait_log(8, 50);
    check("t4_first_id", log_id[6], 0);
    check("t4_second_id", log_id[7], 3);
    check("t4_second_gcd", log_gcd[7], 5);

    // Reset in the middle of a long job.
    step();
    post(1, 65535, 1);
    repeat (10) step();
    check("t5_busy_before", bus.busy, 1);
    base = log_id.size();
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_midcalc");
    step();
    step();
    rst = 1'b0;
    post(3, 8, 12);
    wait_log(base + 1, 50);
    check("t5_one_rsp", log_id.size(), base + 1);
    check("t5_id", log_id[base], 3);
    check("t5_gcd", log_gcd[base], 4);

    // Randomized traffic with back-pressure and withdrawn requests.
    for (int c = 0; c < 600; c++) begin
      step();
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N; i++) begin
        if (!pend_v[i] && $urandom_range(0, 3) == 0) begin
          g0 = rnd_op();
          if ($urandom_range(0, 7) == 0) post(i, g0, g0);
          else post(i, g0, rnd_op());
        end else if (pend_v[i] && $urandom_range(0, 31) == 0) begin
          pend_v[i] = 1'b0;
          drive();
        end
      end
    end
    bus.rsp_ready = 1'b1;
    cnt = 0;
    while ((pend_v != '0 || bus.busy) && cnt < 5000) begin
      step();
      cnt++;
    end
    check("rand_drain", {pend_v != '0, bus.busy}, 0);

    // Longest 16-bit job.
    base = log_id.size();
    step();
    post(2, 65535, 1);
    wait_log(base + 1, 70000);
    check("t6_id", log_id[base], 2);
`ifdef GCD_ARB_TIMEOUT_EN
    check("t6_err", log_err[base], 1);
    check("t6_gcd", log_gcd[base], 0);
    check("t6_calc", log_lat[base] - 1, 1024);
`else
    check("t6_err", log_err[base], 0);
    check("t6_gcd", log_gcd[base], 1);
    check("t6_calc", log_lat[base] - 1, 65535);
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
